// File: rtl/n_bit_adder_if.sv
// n_bit_adder_if
//   Groups the operand, enable and result signals of one adder cell.
//   master: the parent tree stage. It drives en/input1/input2 and reads the results.
//   slave : the adder cell itself.
//   Signals:
//     en              register load enable
//     input1, input2  N-bit two's-complement operands
//     out, cout, ovf  combinational sum and flags
//     out_q, cout_q, ovf_q  registered copies of the sum and flags
interface n_bit_adder_if #(
  parameter int N = 16
);
  logic         en;
  logic [N-1:0] input1;
  logic [N-1:0] input2;
  logic [N-1:0] out;
  logic         cout;
  logic         ovf;
  logic [N-1:0] out_q;
  logic         cout_q;
  logic         ovf_q;

  modport master (
    output en, input1, input2,
    input  out, cout, ovf, out_q, cout_q, ovf_q
  );

  modport slave (
    input  en, input1, input2,
    output out, cout, ovf, out_q, cout_q, ovf_q
  );
endinterface

// File: rtl/n_bit_adder.sv
// n_bit_adder
//   Two's-complement N-bit adder. It is the leaf cell of the adder trees.
//   The sum is built from 4-bit carry-lookahead groups, chained by the group carry.
//   It provides a combinational sum path and a registered copy of that path.
//   Ports:
//     clk    rising-edge clock for the registered path
//     reset  asynchronous active-low reset; it clears the registered outputs only
//     bus    n_bit_adder_if.slave; carries en, the operands and all results
//   N must be a multiple of 4 in the range 4..64.
module n_bit_adder #(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              reset,
  n_bit_adder_if.slave      bus
);

  localparam int NGRP = N / 4;

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic [N-1:0] sum;
  logic         cout_c;
  logic         ovf_c;

  logic [N-1:0] sum_r;
  logic         cout_r;
  logic         ovf_r;

  assign g = bus.input1 & bus.input2;
  assign p = bus.input1 ^ bus.input2;

  assign c[0] = 1'b0;

  // Each group derives all four internal carries straight from its carry-in.
  // Only the group carry ripples from one group to the next.
  for (genvar k = 0; k < NGRP; k++) begin : g_cla
    localparam int B = 4 * k;
    logic ci;
    assign ci = c[B];

    assign c[B+1] = g[B]
                  | (p[B] & ci);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & ci);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & ci);
    assign c[B+4] = g[B+3]
                  | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & ci);
  end

  assign sum    = p ^ c[N-1:0];
  assign cout_c = c[N];
  // Signed overflow: the operands share a sign and the result sign differs from it.
  assign ovf_c  = (bus.input1[N-1] == bus.input2[N-1]) && (sum[N-1] != bus.input1[N-1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (bus.en) begin
      sum_r  <= sum;
      cout_r <= cout_c;
      ovf_r  <= ovf_c;
    end
  end

  assign bus.out    = sum;
  assign bus.cout   = cout_c;
  assign bus.ovf    = ovf_c;
  assign bus.out_q  = sum_r;
  assign bus.cout_q = cout_r;
  assign bus.ovf_q  = ovf_r;

endmodule

// File: tb/tb_n_bit_adder.sv
// tb_n_bit_adder
//   Self-checking bench for n_bit_adder with N = 16.
//   Fixed vectors come from a table. Random vectors use a reference sum of width N+1.
//   Each expected registered result is queued when its stimulus is driven.
//   It is popped and compared after the next clock edge.
module tb_n_bit_adder;

  localparam int N = 16;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk;
  logic reset;

  n_bit_adder_if #(.N(N)) bus ();

  n_bit_adder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   errors;
  vec_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    vec_t        v;
    logic [N:0]  s;
    s      = {1'b0, a} + {1'b0, b};
    v.a    = a;
    v.b    = b;
    v.sum  = s[N-1:0];
    v.cout = s[N];
    v.ovf  = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    return v;
  endfunction

  // Drive one vector mid-cycle and check the combinational outputs.
  // With e = 1, also check the registered outputs one edge later.
  task automatic apply(input vec_t v, input logic e, input string nm);
    vec_t x;
    @(negedge clk);
    bus.input1 = v.a;
    bus.input2 = v.b;
    bus.en     = e;
    #1;
    chk({nm, ".out"},  64'(bus.out),  64'(v.sum));
    chk({nm, ".cout"}, 64'(bus.cout), 64'(v.cout));
    chk({nm, ".ovf"},  64'(bus.ovf),  64'(v.ovf));
    if (e) sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({nm, ".out_q"},  64'(bus.out_q),  64'(x.sum));
      chk({nm, ".cout_q"}, 64'(bus.cout_q), 64'(x.cout));
      chk({nm, ".ovf_q"},  64'(bus.ovf_q),  64'(x.ovf));
    end
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    vecs.push_back('{16'h000B, 16'h000B, 16'h0016, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0});
    vecs.push_back('{16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0});

    // Reset held low while clocking with en = 1: the registers stay 0.
    // The combinational sum still works during reset.
    reset      = 1'b0;
    bus.en     = 1'b1;
    bus.input1 = 16'h000B;
    bus.input2 = 16'h000B;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_q",  64'(bus.out_q),  64'h0);
    chk("rst.cout_q", 64'(bus.cout_q), 64'h0);
    chk("rst.ovf_q",  64'(bus.ovf_q),  64'h0);
    chk("rst.out",    64'(bus.out),    64'h0016);
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i], 1'b1, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      v = model(16'($urandom), 16'($urandom));
      apply(v, 1'b1, $sformatf("rnd%0d", i));
    end

    // Hold: load 0x0053, then drop en and change the inputs.
    apply('{16'h0050, 16'h0003, 16'h0053, 1'b0, 1'b0}, 1'b1, "load");
    apply('{16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b0, 1'b1}, 1'b0, "hold");
    @(posedge clk);
    #1;
    chk("hold.out_q",  64'(bus.out_q),  64'h0053);
    chk("hold.ovf_q",  64'(bus.ovf_q),  64'h0);

    // Reset between clock edges clears the registers at once.
    // The combinational outputs keep following the inputs.
    apply('{16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0}, 1'b1, "pre");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async.out_q", 64'(bus.out_q), 64'h0);
    chk("async.out",   64'(bus.out),   64'h2345);
    @(posedge clk);
    #1;
    chk("async_hold.out_q", 64'(bus.out_q), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    apply('{16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0}, 1'b1, "post");

    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
